// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life cell array: cell indexing,
// the B3/S23 rule constants and the default generation-counter width.
package life_pkg;

    localparam int GEN_W_DEFAULT = 16;

    // B3/S23: a dead cell with exactly three live neighbours is born,
    // a live cell with two or three live neighbours survives.
    localparam logic [3:0] BIRTH_COUNT = 4'd3;
    localparam logic [3:0] SURVIVE_MIN = 4'd2;
    localparam logic [3:0] SURVIVE_MAX = 4'd3;

    // Flat bit position of column col, row row in the val/alive buses.
    function automatic int cell_index(input int col, input int row, input int rows);
        return col * rows + row;
    endfunction

    // Next state of one cell given its current state and live-neighbour count.
    function automatic logic life_rule(input logic cur, input logic [3:0] cnt);
        if (cur) begin
            return (cnt >= SURVIVE_MIN) && (cnt <= SURVIVE_MAX);
        end
        return cnt == BIRTH_COUNT;
    endfunction

endpackage

// File: rtl/life_col_n.sv
// One column of ROWS Life cells. The west/east neighbour columns arrive
// padded with their north/south halo bits (bit 0 = row above row 0), and
// the column's own halo cells arrive on north_nbr/south_nbr.
module life_col_n
    import life_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write_enb,
    input  logic            enable,
    input  logic [ROWS-1:0] val,
    input  logic [ROWS+1:0] west_pad,
    input  logic [ROWS+1:0] east_pad,
    input  logic            north_nbr,
    input  logic            south_nbr,
    output logic [ROWS-1:0] alive,
    output logic [ROWS-1:0] next_alive
);

    logic [ROWS-1:0] cell_q;
    logic [ROWS-1:0] cell_d;
    logic [ROWS+1:0] own_pad;
    logic [7:0]      nbrs;
    logic [3:0]      cnt;

    assign own_pad = {south_nbr, cell_q, north_nbr};
    assign alive   = cell_q;

    // Count the eight neighbours of every cell and apply the Life rule.
    always_comb begin
        next_alive = '0;
        nbrs       = '0;
        cnt        = '0;
        for (int r = 0; r < ROWS; r++) begin
            nbrs = {west_pad[r +: 3], east_pad[r +: 3], own_pad[r], own_pad[r+2]};
            cnt  = '0;
            for (int k = 0; k < 8; k++) begin
                cnt = cnt + {3'b000, nbrs[k]};
            end
            next_alive[r] = life_rule(cell_q[r], cnt);
        end
    end

    // Loading a pattern beats advancing; otherwise hold.
    always_comb begin
        cell_d = cell_q;
        if (write_enb) begin
            cell_d = val;
        end else if (enable) begin
            cell_d = next_alive;
        end
    end

    // Cell state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_q <= '0;
        end else begin
            cell_q <= cell_d;
        end
    end

endmodule

// File: rtl/life_array_grid.sv
// COLS x ROWS Game-of-Life array with single-step and free-run control,
// generation counter, stability flag and a generation-done pulse.
module life_array_grid
    import life_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WRAP    = 0,
    parameter int RUN_DIV = 4,
    parameter int GEN_W   = GEN_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] val,
    input  logic                 write_enb,
    input  logic                 step,
    input  logic                 run_en,
    input  logic                 nw,
    input  logic                 ne,
    input  logic                 se,
    input  logic                 sw,
    input  logic [COLS-1:0]      n,
    input  logic [COLS-1:0]      s,
    input  logic [ROWS-1:0]      e,
    input  logic [ROWS-1:0]      w,
    output logic [ROWS*COLS-1:0] alive,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 gen_done
);

    localparam int              DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam int              PAD_H    = ROWS + 2;

    logic [ROWS*COLS-1:0]        alive_int;
    logic [ROWS*COLS-1:0]        next_flat;
    logic [(COLS+2)*PAD_H-1:0]   pad;

    logic             step_q, step_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic             done_q, done_d;

    logic step_edge;
    logic div_tc;
    logic advance;
    logic apply_gen;

    // In toroidal mode the boundary inputs have no effect on the array.
    logic unused_bnd;
    assign unused_bnd = ^{nw, ne, se, sw, n, s, e, w};

    // Halo-padded copy of the grid: pad column 0 is west of column 0,
    // pad row 0 is north of row 0. Edges come from the boundary inputs
    // or from the opposite side of the grid when wrapping.
    for (genvar gc = 0; gc < COLS + 2; gc++) begin : g_pad_col
        for (genvar gr = 0; gr < PAD_H; gr++) begin : g_pad_row
            if (WRAP != 0) begin : g_wrap
                assign pad[gc*PAD_H + gr] =
                    alive_int[cell_index((gc + COLS - 1) % COLS, (gr + ROWS - 1) % ROWS, ROWS)];
            end else if (gc == 0) begin : g_west
                if (gr == 0) begin : g_c
                    assign pad[gc*PAD_H + gr] = nw;
                end else if (gr == PAD_H - 1) begin : g_c
                    assign pad[gc*PAD_H + gr] = sw;
                end else begin : g_c
                    assign pad[gc*PAD_H + gr] = w[gr-1];
                end
            end else if (gc == COLS + 1) begin : g_east
                if (gr == 0) begin : g_c
                    assign pad[gc*PAD_H + gr] = ne;
                end else if (gr == PAD_H - 1) begin : g_c
                    assign pad[gc*PAD_H + gr] = se;
                end else begin : g_c
                    assign pad[gc*PAD_H + gr] = e[gr-1];
                end
            end else if (gr == 0) begin : g_north
                assign pad[gc*PAD_H + gr] = n[gc-1];
            end else if (gr == PAD_H - 1) begin : g_south
                assign pad[gc*PAD_H + gr] = s[gc-1];
            end else begin : g_cell
                assign pad[gc*PAD_H + gr] = alive_int[cell_index(gc - 1, gr - 1, ROWS)];
            end
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        life_col_n #(
            .ROWS(ROWS)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .write_enb (write_enb),
            .enable    (apply_gen),
            .val       (val[cell_index(gc, 0, ROWS) +: ROWS]),
            .west_pad  (pad[gc*PAD_H +: PAD_H]),
            .east_pad  (pad[(gc+2)*PAD_H +: PAD_H]),
            .north_nbr (pad[(gc+1)*PAD_H]),
            .south_nbr (pad[(gc+1)*PAD_H + PAD_H - 1]),
            .alive     (alive_int[cell_index(gc, 0, ROWS) +: ROWS]),
            .next_alive(next_flat[cell_index(gc, 0, ROWS) +: ROWS])
        );
    end

    assign step_edge = step & ~step_q;
    assign div_tc    = run_en & (div_q == DIV_LAST);
    assign advance   = step_edge | div_tc;
    assign apply_gen = advance & ~write_enb;

    // Next-state logic for step edge detect, divider, counter and flags;
    // a load clears everything and suppresses the generation.
    always_comb begin
        step_d   = write_enb ? 1'b0 : step;
        div_d    = '0;
        gen_d    = gen_q;
        stable_d = stable_q;
        done_d   = apply_gen;
        if (!write_enb && run_en && !div_tc) begin
            div_d = div_q + DIV_W'(1);
        end
        if (write_enb) begin
            gen_d    = '0;
            stable_d = 1'b0;
        end else if (apply_gen) begin
            gen_d    = gen_q + GEN_W'(1);
            stable_d = (next_flat == alive_int);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= 1'b0;
            div_q    <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            step_q   <= step_d;
            div_q    <= div_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            done_q   <= done_d;
        end
    end

    assign alive     = alive_int;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign gen_done  = done_q;

endmodule
